// File: rtl/dmem_responder_if.sv
// Request/response bus between the memory stage (master) and the data-memory
// responder (slave). One request in flight at a time, single-cycle response.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits a fixed
// number of cycles, performs the access on a word array and returns a
// one-cycle response. Reset clears control state but never the array.
module dmem_responder #(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_STATES = 2
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);

  localparam int         DEPTH     = 1 << ADDR_BITS;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        write_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic        err_q;
  logic [15:0] mem_q [DEPTH];

  logic                 accept;
  logic                 enterResp;
  logic                 accWrite;
  logic [15:0]          accAddr;
  logic [15:0]          accWdata;
  logic                 accErr;
  logic [ADDR_BITS-1:0] accIndex;
  logic                 memWe;

  // Pick the request that performs its access this edge: the latched one when
  // leaving WAIT, the live inputs when zero wait states go straight to RESP.
  always_comb begin
    accept    = bus.req_valid && (state_q != S_WAIT);
    enterResp = ((state_q == S_WAIT) && (cnt_q == 4'd0)) ||
                (accept && (WAIT_STATES == 0));
    if (state_q == S_WAIT) begin
      accWrite = write_q;
      accAddr  = addr_q;
      accWdata = wdata_q;
    end else begin
      accWrite = bus.req_write;
      accAddr  = bus.req_addr;
      accWdata = bus.req_wdata;
    end
    accErr   = |(accAddr >> ADDR_BITS);
    accIndex = accAddr[ADDR_BITS-1:0];
    memWe    = reset && enterResp && accWrite && !accErr;
  end

  // Control FSM with registered response data; response fields are zero
  // except during the RESP cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 16'd0;
      wdata_q <= 16'd0;
      rdata_q <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      rdata_q <= 16'd0;
      err_q   <= 1'b0;
      if (enterResp) begin
        rdata_q <= (!accWrite && !accErr) ? mem_q[accIndex] : 16'd0;
        err_q   <= accErr;
      end
      if (accept) begin
        write_q <= bus.req_write;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      case (state_q)
        S_IDLE, S_RESP: begin
          if (accept) begin
            state_q <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
            cnt_q   <= WAIT_LOAD;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Array write; held off by reset so a coinciding store is discarded.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem_q[accIndex] <= accWdata;
    end
  end

  assign bus.req_ready  = (state_q != S_WAIT);
  assign bus.busy       = (state_q == S_WAIT);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states and
// one with zero wait states, sharing clock and reset.
module tb_dmem_responder;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  dmem_responder_if bus2 ();
  dmem_responder_if bus0 ();

  dmem_responder #(.ADDR_BITS(8), .WAIT_STATES(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  dmem_responder #(.ADDR_BITS(8), .WAIT_STATES(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus2(input logic v, input logic w,
                                input logic [15:0] a, input logic [15:0] d);
    bus2.req_valid = v;
    bus2.req_write = w;
    bus2.req_addr  = a;
    bus2.req_wdata = d;
  endtask

  task automatic applyStimulus0(input logic v, input logic w,
                                input logic [15:0] a, input logic [15:0] d);
    bus0.req_valid = v;
    bus0.req_write = w;
    bus0.req_addr  = a;
    bus0.req_wdata = d;
  endtask

  // Full transaction on the two-wait-state instance starting from IDLE.
  task automatic txn2(input string tag, input logic w, input logic [15:0] a,
                      input logic [15:0] d, input logic [15:0] expR, input logic expE);
    applyStimulus2(1'b1, w, a, d);
    checkOutput({tag, "/ready"}, 16'(bus2.req_ready), 16'd1);
    tick();
    applyStimulus2(1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput({tag, "/busy1"}, 16'(bus2.busy), 16'd1);
    checkOutput({tag, "/rv1"}, 16'(bus2.resp_valid), 16'd0);
    tick();
    checkOutput({tag, "/busy2"}, 16'(bus2.busy), 16'd1);
    checkOutput({tag, "/rv2"}, 16'(bus2.resp_valid), 16'd0);
    tick();
    checkOutput({tag, "/rv3"}, 16'(bus2.resp_valid), 16'd1);
    checkOutput({tag, "/rdata"}, bus2.resp_rdata, expR);
    checkOutput({tag, "/err"}, 16'(bus2.resp_err), 16'(expE));
    checkOutput({tag, "/busy3"}, 16'(bus2.busy), 16'd0);
    tick();
    checkOutput({tag, "/rv4"}, 16'(bus2.resp_valid), 16'd0);
    checkOutput({tag, "/rdata4"}, bus2.resp_rdata, 16'd0);
    checkOutput({tag, "/err4"}, 16'(bus2.resp_err), 16'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    applyStimulus2(1'b0, 1'b0, 16'h0000, 16'h0000);
    applyStimulus0(1'b0, 1'b0, 16'h0000, 16'h0000);

    // Reset values
    tick();
    tick();
    checkOutput("rst/ready", 16'(bus2.req_ready), 16'd1);
    checkOutput("rst/rv", 16'(bus2.resp_valid), 16'd0);
    checkOutput("rst/rdata", bus2.resp_rdata, 16'd0);
    checkOutput("rst/err", 16'(bus2.resp_err), 16'd0);
    checkOutput("rst/busy", 16'(bus2.busy), 16'd0);
    checkOutput("rst0/ready", 16'(bus0.req_ready), 16'd1);
    checkOutput("rst0/rv", 16'(bus0.resp_valid), 16'd0);
    reset = 1'b1;
    tick();

    // Preload known contents
    $display("[TB] preload");
    txn2("pre13", 1'b1, 16'h0013, 16'h1357, 16'h0000, 1'b0);
    txn2("pre00", 1'b1, 16'h0000, 16'hCAFE, 16'h0000, 1'b0);
    txn2("pre20", 1'b1, 16'h0020, 16'h1111, 16'h0000, 1'b0);

    // Store then loads
    txn2("st12", 1'b1, 16'h0012, 16'hBEEF, 16'h0000, 1'b0);
    txn2("ld12", 1'b0, 16'h0012, 16'h0000, 16'hBEEF, 1'b0);
    txn2("ld13", 1'b0, 16'h0013, 16'h0000, 16'h1357, 1'b0);

    // Out-of-range store, no aliasing
    txn2("st100", 1'b1, 16'h0100, 16'h1234, 16'h0000, 1'b1);
    txn2("ld00", 1'b0, 16'h0000, 16'h0000, 16'hCAFE, 1'b0);
    txn2("ldF000", 1'b0, 16'hF000, 16'h0000, 16'h0000, 1'b1);

    // Request held while not ready, accepted on the RESP edge
    $display("[TB] held request");
    applyStimulus2(1'b1, 1'b1, 16'h0030, 16'h4242);
    tick();
    applyStimulus2(1'b1, 1'b0, 16'h0030, 16'h0000);
    checkOutput("hold/ready0", 16'(bus2.req_ready), 16'd0);
    tick();
    checkOutput("hold/ready1", 16'(bus2.req_ready), 16'd0);
    checkOutput("hold/busy1", 16'(bus2.busy), 16'd1);
    tick();
    checkOutput("hold/rvA", 16'(bus2.resp_valid), 16'd1);
    checkOutput("hold/readyA", 16'(bus2.req_ready), 16'd1);
    checkOutput("hold/rdataA", bus2.resp_rdata, 16'd0);
    tick();
    applyStimulus2(1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput("hold/busyB", 16'(bus2.busy), 16'd1);
    checkOutput("hold/rvB0", 16'(bus2.resp_valid), 16'd0);
    tick();
    checkOutput("hold/rvB1", 16'(bus2.resp_valid), 16'd0);
    tick();
    checkOutput("hold/rvB", 16'(bus2.resp_valid), 16'd1);
    checkOutput("hold/rdataB", bus2.resp_rdata, 16'h4242);
    tick();
    checkOutput("hold/rvEnd", 16'(bus2.resp_valid), 16'd0);

    // Reset during WAIT abandons the store
    $display("[TB] reset during wait");
    applyStimulus2(1'b1, 1'b1, 16'h0020, 16'h7777);
    tick();
    applyStimulus2(1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput("rw/busy", 16'(bus2.busy), 16'd1);
    reset = 1'b0;
    tick();
    checkOutput("rw/ready", 16'(bus2.req_ready), 16'd1);
    checkOutput("rw/rv", 16'(bus2.resp_valid), 16'd0);
    checkOutput("rw/rdata", bus2.resp_rdata, 16'd0);
    checkOutput("rw/err", 16'(bus2.resp_err), 16'd0);
    checkOutput("rw/busy0", 16'(bus2.busy), 16'd0);
    reset = 1'b1;
    tick();
    checkOutput("rw/rv1", 16'(bus2.resp_valid), 16'd0);
    tick();
    checkOutput("rw/rv2", 16'(bus2.resp_valid), 16'd0);
    tick();
    txn2("ld20", 1'b0, 16'h0020, 16'h0000, 16'h1111, 1'b0);

    // Zero wait states, back-to-back
    $display("[TB] zero wait back-to-back");
    applyStimulus0(1'b1, 1'b1, 16'h0005, 16'hA5A5);
    tick();
    checkOutput("b2b/rv1", 16'(bus0.resp_valid), 16'd1);
    checkOutput("b2b/rd1", bus0.resp_rdata, 16'h0000);
    checkOutput("b2b/ready1", 16'(bus0.req_ready), 16'd1);
    applyStimulus0(1'b1, 1'b0, 16'h0005, 16'h0000);
    tick();
    checkOutput("b2b/rv2", 16'(bus0.resp_valid), 16'd1);
    checkOutput("b2b/rd2", bus0.resp_rdata, 16'hA5A5);
    checkOutput("b2b/busy2", 16'(bus0.busy), 16'd0);
    applyStimulus0(1'b1, 1'b1, 16'h0006, 16'h5A5A);
    tick();
    checkOutput("b2b/rv3", 16'(bus0.resp_valid), 16'd1);
    checkOutput("b2b/rd3", bus0.resp_rdata, 16'h0000);
    applyStimulus0(1'b1, 1'b0, 16'h0006, 16'h0000);
    tick();
    checkOutput("b2b/rv4", 16'(bus0.resp_valid), 16'd1);
    checkOutput("b2b/rd4", bus0.resp_rdata, 16'h5A5A);
    checkOutput("b2b/err4", 16'(bus0.resp_err), 16'd0);
    applyStimulus0(1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    checkOutput("b2b/rv5", 16'(bus0.resp_valid), 16'd0);
    checkOutput("b2b/rd5", bus0.resp_rdata, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
